// File: rtl/ntt_defines_pkg.sv
// Shared definitions for the masked special-adder scheduler: FSM state encoding
// and default sizing constants.
package ntt_defines_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } sadd_state_t;

    localparam int SADD_WIDTH = 23;
    localparam int SADD_LAT   = SADD_WIDTH + 3;
    localparam int SADD_DEPTH = 32;
    localparam int SADD_CNTW  = 9;

endpackage

// File: rtl/ntt_masked_sadd_obuf.sv
// Result buffer for the masked special adder: synchronous FIFO holding
// {share1, share0, last} entries, with occupancy output and synchronous clear.
module ntt_masked_sadd_obuf
    import ntt_defines_pkg::*;
#(
    parameter int DW    = 2 * SADD_WIDTH + 1,
    parameter int DEPTH = SADD_DEPTH,
    parameter int OCCW  = $clog2(DEPTH + 1)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            zeroize,
    input  logic            wr_en,
    input  logic [DW-1:0]   wr_data,
    input  logic            rd_en,
    output logic            rd_valid,
    output logic [DW-1:0]   rd_data,
    output logic [OCCW-1:0] occupancy
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DW-1:0]   mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [OCCW-1:0] occ_q;
    logic            do_wr;
    logic            do_rd;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign rd_valid  = (occ_q != '0);
    assign do_rd     = rd_en & rd_valid;
    // A full buffer still accepts a write when the head leaves in the same cycle.
    assign do_wr     = wr_en & ((occ_q != OCCW'(DEPTH)) | do_rd);
    assign rd_data   = rd_valid ? mem[rd_ptr] : '0;
    assign occupancy = occ_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ_q  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (zeroize) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ_q  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (do_wr) begin
                mem[wr_ptr] <= wr_data;
                wr_ptr      <= ptr_inc(wr_ptr);
            end
            if (do_rd) rd_ptr <= ptr_inc(rd_ptr);
            case ({do_wr, do_rd})
                2'b10:   occ_q <= occ_q + 1'b1;
                2'b01:   occ_q <= occ_q - 1'b1;
                default: occ_q <= occ_q;
            endcase
        end
    end

endmodule

// File: rtl/ntt_masked_sadd_sched.sv
// Issue scheduler for a fixed-latency masked special adder: credit-based issue,
// valid/last tag pipeline matching the adder latency, and a result buffer.
module ntt_masked_sadd_sched
    import ntt_defines_pkg::*;
#(
    parameter int WIDTH = SADD_WIDTH,
    parameter int LAT   = WIDTH + 3,
    parameter int DEPTH = SADD_DEPTH,
    parameter int CNTW  = SADD_CNTW
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               zeroize,
    input  logic               start,
    input  logic [CNTW-1:0]    num_coeffs,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               rnd_valid,
    output logic               issue,
    input  logic [2*WIDTH-1:0] res_masked,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] out_masked,
    output logic               out_last,
    output logic               busy,
    output logic               done
);

    localparam int IFW  = $clog2(LAT + 1);
    localparam int OCCW = $clog2(DEPTH + 1);
    localparam int CRW  = ((IFW > OCCW) ? IFW : OCCW) + 1;

    sadd_state_t       state_q;
    logic [CNTW-1:0]   num_q;
    logic [CNTW-1:0]   issued_q;
    logic [IFW-1:0]    inflight_q;
    logic [LAT-1:0]    tag_vld_p;
    logic [LAT-1:0]    tag_last_p;

    logic [OCCW-1:0]   occupancy;
    logic [CRW-1:0]    credit_used;
    logic              credit_ok;
    logic              issue_last;
    logic              wr_en;
    logic              wr_last;
    logic              pop;
    logic              drain_empty;
    logic [2*WIDTH:0]  buf_rd_data;

    // Results already in flight are counted against buffer space so the adder
    // pipeline never needs back-pressure.
    assign credit_used = CRW'(inflight_q) + CRW'(occupancy);
    assign credit_ok   = credit_used < CRW'(DEPTH);

    assign issue      = (state_q == RUN) & in_valid & rnd_valid & credit_ok & (issued_q < num_q);
    assign in_ready   = issue;
    assign issue_last = issue & (CNTW'(issued_q + 1'b1) == num_q);

    assign wr_en   = tag_vld_p[LAT-1];
    assign wr_last = tag_last_p[LAT-1];
    assign pop     = out_valid & out_ready;

    // Completion is taken on the cycle the final entry leaves the buffer.
    assign drain_empty = (inflight_q == '0) &
                         ((occupancy == '0) | ((occupancy == OCCW'(1)) & pop));

    assign busy = (state_q != IDLE);
    assign done = (state_q == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            num_q    <= '0;
            issued_q <= '0;
        end else if (zeroize) begin
            state_q  <= IDLE;
            num_q    <= '0;
            issued_q <= '0;
        end else begin
            if (issue) issued_q <= issued_q + 1'b1;
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        num_q    <= num_coeffs;
                        issued_q <= '0;
                        state_q  <= (num_coeffs != '0) ? RUN : DONE;
                    end
                end
                RUN: begin
                    if (issued_q == num_q) state_q <= DRAIN;
                end
                DRAIN: begin
                    if (drain_empty) state_q <= DONE;
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Tag pipeline: stage p0 captures the issue, stage LAT-1 lines up with res_masked.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_vld_p  <= '0;
            tag_last_p <= '0;
            inflight_q <= '0;
        end else if (zeroize) begin
            tag_vld_p  <= '0;
            tag_last_p <= '0;
            inflight_q <= '0;
        end else begin
            tag_vld_p  <= {tag_vld_p[LAT-2:0], issue};
            tag_last_p <= {tag_last_p[LAT-2:0], issue_last};
            inflight_q <= inflight_q + IFW'(issue) - IFW'(wr_en);
        end
    end

    ntt_masked_sadd_obuf #(
        .DW    (2 * WIDTH + 1),
        .DEPTH (DEPTH),
        .OCCW  (OCCW)
    ) u_obuf (
        .clk       (clk),
        .rst_n     (rst_n),
        .zeroize   (zeroize),
        .wr_en     (wr_en),
        .wr_data   ({res_masked, wr_last}),
        .rd_en     (out_ready),
        .rd_valid  (out_valid),
        .rd_data   (buf_rd_data),
        .occupancy (occupancy)
    );

    assign out_masked = buf_rd_data[2*WIDTH:1];
    assign out_last   = buf_rd_data[0];

endmodule

// File: tb/tb_ntt_masked_sadd_sched.sv
// Scoreboard bench for ntt_masked_sadd_sched with a behavioural fixed-latency
// adder producing per-coefficient tagged results.
module tb_ntt_masked_sadd_sched;

    localparam int W     = 23;
    localparam int LAT   = W + 3;
    localparam int DEPTH = 32;
    localparam int CNTW  = 9;

    typedef struct packed {
        logic [2*W-1:0] d;
        logic           l;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            zeroize;
    logic            start;
    logic [CNTW-1:0] num_coeffs;
    logic            in_valid;
    logic            in_ready;
    logic            rnd_valid;
    logic            issue;
    logic [2*W-1:0]  res_masked;
    logic            out_valid;
    logic            out_ready;
    logic [2*W-1:0]  out_masked;
    logic            out_last;
    logic            busy;
    logic            done;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int issues_total = 0;
    int pops_total = 0;
    int done_total = 0;
    int last_pop_cyc = 0;
    int done_cyc = 0;
    int blk = 0;
    int adder_k = 0;
    exp_t sb[$];
    logic [2*W-1:0] apipe [LAT];

    ntt_masked_sadd_sched #(
        .WIDTH (W),
        .LAT   (LAT),
        .DEPTH (DEPTH),
        .CNTW  (CNTW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .zeroize    (zeroize),
        .start      (start),
        .num_coeffs (num_coeffs),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .rnd_valid  (rnd_valid),
        .issue      (issue),
        .res_masked (res_masked),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_masked (out_masked),
        .out_last   (out_last),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [2*W-1:0] mk_res(input int b, input int k);
        logic [W-1:0] s0;
        logic [W-1:0] s1;
        s0 = W'(b * 4096 + k * 3 + 1);
        s1 = W'(32'h5A5A5 ^ (k * 5 + b));
        return {s1, s0};
    endfunction

    // Adder model: result of the k-th issue of the block appears LAT cycles later;
    // idle slots carry an all-ones pattern.
    always @(posedge clk) begin
        for (int i = LAT - 1; i > 0; i--) apipe[i] <= apipe[i-1];
        apipe[0] <= issue ? mk_res(blk, adder_k) : {2*W{1'b1}};
        if (start && !busy) adder_k <= 0;
        else if (issue)     adder_k <= adder_k + 1;
    end
    assign res_masked = apipe[LAT-1];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", nm, act, req);
        end
    endtask

    // Monitor: counts events and pops expected results from the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (issue) begin
            issues_total++;
            chk("issue_gated", {62'd0, rnd_valid, in_valid}, 64'd3);
        end
        if (out_valid && out_ready) begin
            pops_total++;
            last_pop_cyc = cyc;
            if (sb.size() == 0) begin
                chk("pop_unexpected", 64'd1, 64'd0);
            end else begin
                e = sb.pop_front();
                chk("out_masked", 64'(out_masked), 64'(e.d));
                chk("out_last", 64'(out_last), 64'(e.l));
            end
        end
        if (done) begin
            done_total++;
            done_cyc = cyc;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_block(input int n);
        exp_t e;
        blk++;
        for (int k = 0; k < n; k++) begin
            e.d = mk_res(blk, k);
            e.l = (k == n - 1);
            sb.push_back(e);
        end
        num_coeffs = CNTW'(n);
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int d0, input int budget, input string nm);
        int n;
        n = 0;
        while (done_total == d0 && n < budget) begin
            tick();
            n++;
        end
        if (done_total == d0) begin
            checks++;
            errors++;
            $display("FAIL %s: no done within %0d cycles, required a done pulse", nm, budget);
        end
    endtask

    task automatic chk_reset_outputs(input string nm);
        chk({nm, "_in_ready"}, 64'(in_ready), 64'd0);
        chk({nm, "_issue"}, 64'(issue), 64'd0);
        chk({nm, "_out_valid"}, 64'(out_valid), 64'd0);
        chk({nm, "_out_masked"}, 64'(out_masked), 64'd0);
        chk({nm, "_out_last"}, 64'(out_last), 64'd0);
        chk({nm, "_busy"}, 64'(busy), 64'd0);
        chk({nm, "_done"}, 64'(done), 64'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int i0, p0, d0, c0, c1, n;
        rst_n = 1'b0; zeroize = 1'b0; start = 1'b0; num_coeffs = '0;
        in_valid = 1'b0; rnd_valid = 1'b0; out_ready = 1'b0;
        repeat (3) tick();
        chk_reset_outputs("reset");
        rst_n = 1'b1;
        tick();

        // Full-rate block of 256.
        in_valid = 1'b1; rnd_valid = 1'b1; out_ready = 1'b1;
        i0 = issues_total; p0 = pops_total; d0 = done_total;
        start_block(256);
        n = 0;
        do begin @(negedge clk); n++; end while (!issue && n < 10);
        c0 = cyc;
        n = 0;
        do begin @(negedge clk); n++; end while (!out_valid && n < 60);
        c1 = cyc;
        chk("A_first_out_latency", 64'(c1 - (c0 + 1)), 64'd26);
        while (cyc < c0 + 256) tick();
        chk("A_issues_consecutive", 64'(issues_total - i0), 64'd256);
        wait_done(d0, 400, "A_done");
        chk("A_done_after_last_pop", 64'(done_cyc - last_pop_cyc), 64'd1);
        chk("A_pops", 64'(pops_total - p0), 64'd256);
        chk("A_issues", 64'(issues_total - i0), 64'd256);
        chk("A_sb_empty", 64'(sb.size()), 64'd0);
        tick();

        // Back-pressure: buffer fills to DEPTH, then drains in order.
        out_ready = 1'b0;
        i0 = issues_total; p0 = pops_total; d0 = done_total;
        start_block(64);
        repeat (80) tick();
        chk("B_issues_capped", 64'(issues_total - i0), 64'd32);
        chk("B_occupancy", 64'(dut.occupancy), 64'd32);
        chk("B_out_valid", 64'(out_valid), 64'd1);
        chk("B_no_pops", 64'(pops_total - p0), 64'd0);
        out_ready = 1'b1;
        wait_done(d0, 300, "B_done");
        chk("B_pops", 64'(pops_total - p0), 64'd64);
        chk("B_issues", 64'(issues_total - i0), 64'd64);
        chk("B_sb_empty", 64'(sb.size()), 64'd0);
        tick();

        // Randomness available every other cycle.
        i0 = issues_total; p0 = pops_total; d0 = done_total;
        start_block(10);
        n = 0;
        while (done_total == d0 && n < 200) begin
            rnd_valid = ~rnd_valid;
            tick();
            n++;
        end
        rnd_valid = 1'b1;
        chk("C_done_seen", 64'(done_total - d0), 64'd1);
        chk("C_pops", 64'(pops_total - p0), 64'd10);
        chk("C_issues", 64'(issues_total - i0), 64'd10);
        tick();

        // Empty block.
        i0 = issues_total; d0 = done_total;
        start_block(0);
        chk("D_done_now", 64'(done), 64'd1);
        tick();
        chk("D_done_cleared", 64'(done), 64'd0);
        chk("D_busy_cleared", 64'(busy), 64'd0);
        chk("D_done_count", 64'(done_total - d0), 64'd1);
        chk("D_issues", 64'(issues_total - i0), 64'd0);

        // Zeroize on the 100th issue, then a short block.
        i0 = issues_total; d0 = done_total;
        start_block(256);
        n = 0;
        while (issues_total - i0 < 99 && n < 300) begin tick(); n++; end
        zeroize = 1'b1;
        chk("E_issue100", 64'(issue), 64'd1);
        tick();
        zeroize = 1'b0;
        sb.delete();
        chk("E_busy", 64'(busy), 64'd0);
        chk("E_out_valid", 64'(out_valid), 64'd0);
        chk("E_issue", 64'(issue), 64'd0);
        chk("E_out_masked", 64'(out_masked), 64'd0);
        p0 = pops_total;
        repeat (40) tick();
        chk("E_no_done", 64'(done_total - d0), 64'd0);
        chk("E_no_pops", 64'(pops_total - p0), 64'd0);
        d0 = done_total;
        start_block(4);
        wait_done(d0, 100, "E_done");
        chk("E_pops_after", 64'(pops_total - p0), 64'd4);

        // Asynchronous reset while draining.
        tick();
        out_ready = 1'b0;
        d0 = done_total;
        start_block(8);
        repeat (45) tick();
        chk("F_in_drain", 64'(dut.state_q), 64'd2);
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("F_reset");
        sb.delete();
        tick();
        tick();
        rst_n = 1'b1;
        out_ready = 1'b1;
        p0 = pops_total;
        repeat (5) tick();
        chk("F_no_done", 64'(done_total - d0), 64'd0);
        d0 = done_total;
        start_block(5);
        wait_done(d0, 100, "F_done");
        chk("F_pops_after", 64'(pops_total - p0), 64'd5);
        chk("F_sb_empty", 64'(sb.size()), 64'd0);

        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
